// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC operand feeder.
package mac_pkg;

    localparam int DW           = 8;
    localparam int DEPTH        = 8;
    localparam int FLUSH_CYCLES = 3;
    localparam int RES_W        = 2 * DW;

    // Width of the flush-cycle counter.
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    // Width needed to hold a pair count of 0..depth.
    function automatic int len_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mac_pair_buf.sv
// Operand-pair storage: DEPTH-entry register array, one write port and one
// indexed combinational read port. Data is deliberately not reset; the
// feeder only ever reads entries written during the current burst.
module mac_pair_buf #(
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_idx_i,
    input  logic [DW-1:0] wr_a_i,
    input  logic [DW-1:0] wr_b_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [DW-1:0] rd_a_o,
    output logic [DW-1:0] rd_b_o
);

    logic [DW-1:0] mem_a_q [DEPTH];
    logic [DW-1:0] mem_b_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Each entry captures the incoming pair when it is the write target.
            always_ff @(posedge clk) begin
                if (wr_en_i && (wr_idx_i == AW'(gi))) begin
                    mem_a_q[gi] <= wr_a_i;
                    mem_b_q[gi] <= wr_b_i;
                end
            end
        end
    endgenerate

    assign rd_a_o = mem_a_q[rd_idx_i];
    assign rd_b_o = mem_b_q[rd_idx_i];

endmodule

// File: rtl/mac_feeder.sv
// Buffers a burst of operand pairs, streams them into an external MAC unit,
// pads with zero operands while the MAC pipeline drains, then captures and
// holds the accumulated dot product until it is accepted downstream.
module mac_feeder #(
    parameter int DEPTH = mac_pkg::DEPTH,
    parameter int DW    = mac_pkg::DW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_a,
    input  logic [DW-1:0]           in_b,
    input  logic                    in_last,
    output logic                    mac_en,
    output logic [DW-1:0]           mac_a,
    output logic [DW-1:0]           mac_b,
    input  logic                    mac_valid,
    input  logic [2*DW-1:0]         mac_c,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DW-1:0]         res_data,
    output logic [$clog2(DEPTH):0]  res_len,
    output logic                    res_err,
    output logic                    res_trunc,
    output logic                    busy
);

    import mac_pkg::*;

    localparam int CW = len_width(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = 2 * DW;

    localparam logic [CW-1:0]      LAST_SLOT  = CW'(DEPTH - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;       // pairs loaded so far / next write slot
    logic [CW-1:0]        idx_q;       // pair currently presented to the MAC
    logic [CW-1:0]        len_q;       // pairs in the burst being processed
    logic                 trunc_q;     // burst closed by a full buffer
    logic [FLUSH_W-1:0]   flush_q;
    logic [RW-1:0]        res_data_q;
    logic [CW-1:0]        res_len_q;
    logic                 res_err_q;
    logic                 res_trunc_q;

    logic                 load_fire;
    logic                 load_close;
    logic                 run_done;
    logic                 flush_done;
    logic [DW-1:0]        rd_a;
    logic [DW-1:0]        rd_b;

    assign load_fire  = (state_q == ST_LOAD) && in_valid;
    assign load_close = load_fire && (in_last || (cnt_q == LAST_SLOT));
    assign run_done   = (idx_q == (len_q - CW'(1)));
    assign flush_done = (flush_q == FLUSH_LAST);

    mac_pair_buf #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_buf (
        .clk      (clk),
        .wr_en_i  (load_fire),
        .wr_idx_i (cnt_q[AW-1:0]),
        .wr_a_i   (in_a),
        .wr_b_i   (in_b),
        .rd_idx_i (idx_q[AW-1:0]),
        .rd_a_o   (rd_a),
        .rd_b_o   (rd_b)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:   if (load_close) state_d = ST_RUN;
            ST_RUN:    if (run_done)   state_d = ST_FLUSH;
            ST_FLUSH:  if (flush_done) state_d = ST_RESULT;
            ST_RESULT: if (res_ready)  state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
    end

    // Outputs decoded from state; operands are forced to zero outside RUN so
    // the drain cycles push only zero products through the MAC.
    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        busy      = (state_q != ST_LOAD);
        mac_en    = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        mac_a     = '0;
        mac_b     = '0;
        res_valid = (state_q == ST_RESULT);
        if (state_q == ST_RUN) begin
            mac_a = rd_a;
            mac_b = rd_b;
        end
    end

    // Counters, burst bookkeeping and the result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            flush_q     <= '0;
            res_data_q  <= '0;
            res_len_q   <= '0;
            res_err_q   <= 1'b0;
            res_trunc_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    idx_q   <= '0;
                    flush_q <= '0;
                    if (load_fire) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    if (load_close) begin
                        len_q   <= cnt_q + CW'(1);
                        trunc_q <= ~in_last;
                    end
                end
                ST_RUN: begin
                    idx_q <= idx_q + CW'(1);
                end
                ST_FLUSH: begin
                    flush_q <= flush_q + FLUSH_W'(1);
                    if (flush_done) begin
                        flush_q     <= '0;
                        res_data_q  <= mac_c;
                        res_err_q   <= ~mac_valid;
                        res_len_q   <= len_q;
                        res_trunc_q <= trunc_q;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        cnt_q <= '0;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign res_data  = res_data_q;
    assign res_len   = res_len_q;
    assign res_err   = res_err_q;
    assign res_trunc = res_trunc_q;

endmodule
